// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x-oversampling UART receiver with majority-vote sampling; `UART_RX_PARITY_EN selects 8E1
module uart_rx_os #(
    parameter int SYS_CLOCK = 50_000_000,
    parameter int BAUDRATE  = 115200,
    parameter int OS_DIV    = SYS_CLOCK / (BAUDRATE * 16)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int TW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state, state_nxt;
    logic            rx_s1, rx_s2, rx_prev;
    logic            fall;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [3:0]      samp_cnt;
    logic            s7, s8, maj;
    logic            decide, bit_end;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            good_d, ferr_d, perr_d;

    // Synchroniser and edge history idle high so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall    = rx_prev & ~rx_s2;
    assign tick    = (tick_cnt == TW'(OS_DIV - 1));
    assign decide  = tick && (samp_cnt == 4'd9);
    assign bit_end = tick && (samp_cnt == 4'd15);
    assign maj     = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            samp_cnt <= 4'd0;
            s7       <= 1'b1;
            s8       <= 1'b1;
            bit_cnt  <= 3'd0;
        end else if (state == S_IDLE) begin
            tick_cnt <= '0;
            samp_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                samp_cnt <= samp_cnt + 4'd1;
                if (samp_cnt == 4'd7) s7 <= rx_s2;
                if (samp_cnt == 4'd8) s8 <= rx_s2;
            end
            if (state == S_DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'h00;
        end else if (state == S_DATA && decide) begin
            shift_reg <= {maj, shift_reg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (state == S_PARITY && decide) begin
            par_bit <= maj;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (fall) state_nxt = S_START;
            S_START: begin
                if (decide && maj) state_nxt = S_IDLE;
                else if (bit_end)  state_nxt = S_DATA;
            end
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (bit_end && bit_cnt == 3'd7) state_nxt = S_PARITY;
            S_PARITY: if (bit_end) state_nxt = S_STOP;
`else
            S_DATA:   if (bit_end && bit_cnt == 3'd7) state_nxt = S_STOP;
`endif
            S_STOP:   if (decide) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Stop decision drives registered pulses; a parity mismatch suppresses the good-byte pulse
    always_comb begin
        rx_busy = (state != S_IDLE);
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = (state == S_STOP) && decide && (^{shift_reg, par_bit});
`endif
        ferr_d  = (state == S_STOP) && decide && !maj;
        good_d  = (state == S_STOP) && decide && maj && !perr_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= 8'h00;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_vld    <= good_d;
            frame_err <= ferr_d;
            if (good_d) rx_data <= shift_reg;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= perr_d;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed bench for uart_rx_os at 50 MHz / 115200 baud
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_vld, frame_err, parity_err, rx_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc = 0;
    int vld_cycles = 0, ferr_cycles = 0, perr_cycles = 0, excl_bad = 0;
    int log_n = 0;
    int last_vld_cyc = 0;
    int start_cyc = 0;
    logic [7:0] data_log [0:63];
    int v0, f0, p0, l0;

    uart_rx_os dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .rx_busy    (rx_busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_vld) begin
            vld_cycles   <= vld_cycles + 1;
            last_vld_cyc <= cyc;
            if (log_n < 64) data_log[log_n] <= rx_data;
            log_n <= log_n + 1;
        end
        if (frame_err)  ferr_cycles <= ferr_cycles + 1;
        if (parity_err) perr_cycles <= perr_cycles + 1;
        if (rx_vld && (frame_err || parity_err)) excl_bad <= excl_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int cpb, input logic par_flip);
        uart_rx   = 1'b0;
        start_cyc = cyc;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (cpb) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^d) ^ par_flip;
        repeat (cpb) @(negedge clk);
`endif
        uart_rx = stop_b;
        repeat (cpb) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic snap();
        v0 = vld_cycles;
        f0 = ferr_cycles;
        p0 = perr_cycles;
        l0 = log_n;
    endtask

    initial begin
        // Reset state
        idle(5);
        check("rst_rx_data",    rx_data,    8'h00);
        check("rst_rx_vld",     rx_vld,     1'b0);
        check("rst_frame_err",  frame_err,  1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_rx_busy",    rx_busy,    1'b0);
        rst_n = 1'b1;
        idle(50);

        // Single good byte and latency window
        snap();
        send_frame(8'h55, 1'b1, 434, 1'b0);
        idle(600);
        check("b55_vld_count", vld_cycles - v0, 1);
        check("b55_rx_data",   rx_data, 8'h55);
        check("b55_log",       data_log[l0], 8'h55);
        check("b55_ferr",      ferr_cycles - f0, 0);
        check("b55_busy_low",  rx_busy, 1'b0);
        check("b55_latency_window",
              ((last_vld_cyc - start_cyc) >= 4100 && (last_vld_cyc - start_cyc) <= 4250), 1'b1);

        // 100-clock glitch is rejected as a false start
        snap();
        uart_rx = 1'b0;
        idle(10);
        check("glitch_busy_seen", rx_busy, 1'b1);
        idle(90);
        uart_rx = 1'b1;
        idle(300);
        check("glitch_busy_low", rx_busy, 1'b0);
        check("glitch_no_vld",   vld_cycles - v0, 0);
        check("glitch_no_ferr",  ferr_cycles - f0, 0);
        check("glitch_rx_data",  rx_data, 8'h55);

        // Framing error keeps the previous good byte
        send_frame(8'h11, 1'b1, 434, 1'b0);
        idle(300);
        check("b11_rx_data", rx_data, 8'h11);
        snap();
        send_frame(8'hA3, 1'b0, 434, 1'b0);
        idle(600);
        check("ferr_count",   ferr_cycles - f0, 1);
        check("ferr_no_vld",  vld_cycles - v0, 0);
        check("ferr_rx_data", rx_data, 8'h11);
        check("ferr_busy",    rx_busy, 1'b0);

        // Back-to-back frames from a transmitter running 2% fast
        snap();
        send_frame(8'h00, 1'b1, 425, 1'b0);
        send_frame(8'hFF, 1'b1, 425, 1'b0);
        idle(600);
        check("b2b_vld_count", vld_cycles - v0, 2);
        check("b2b_first",     data_log[l0], 8'h00);
        check("b2b_second",    data_log[l0 + 1], 8'hFF);
        check("b2b_ferr",      ferr_cycles - f0, 0);
        check("b2b_rx_data",   rx_data, 8'hFF);

        // Reset during bit 4, released while the line is high in bit 6
        snap();
        fork
            send_frame(8'hC3, 1'b1, 434, 1'b0);
            begin
                idle(5 * 434 + 200);
                check("midrst_busy_before", rx_busy, 1'b1);
                rst_n = 1'b0;
                #1;
                check("midrst_rx_data",   rx_data,   8'h00);
                check("midrst_rx_busy",   rx_busy,   1'b0);
                check("midrst_rx_vld",    rx_vld,    1'b0);
                check("midrst_frame_err", frame_err, 1'b0);
                idle(2 * 434);
                rst_n = 1'b1;
            end
        join
        idle(600);
        check("midrst_no_vld",  vld_cycles - v0, 0);
        check("midrst_no_ferr", ferr_cycles - f0, 0);
        send_frame(8'h3C, 1'b1, 434, 1'b0);
        idle(600);
        check("after_rst_vld_count", vld_cycles - v0, 1);
        check("after_rst_rx_data",   rx_data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        // Wrong parity suppresses the byte, correct parity delivers it
        snap();
        send_frame(8'h07, 1'b1, 434, 1'b1);
        idle(600);
        check("par_bad_perr",    perr_cycles - p0, 1);
        check("par_bad_no_vld",  vld_cycles - v0, 0);
        check("par_bad_rx_data", rx_data, 8'h3C);
        snap();
        send_frame(8'h07, 1'b1, 434, 1'b0);
        idle(600);
        check("par_good_vld",     vld_cycles - v0, 1);
        check("par_good_rx_data", rx_data, 8'h07);
        check("par_good_no_perr", perr_cycles - p0, 0);
`else
        check("no_parity_err_ever", perr_cycles, 0);
`endif
        check("pulse_exclusive", excl_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver, 8N1, LSB first; the receive end of the link that the team's UART transmitter drives.
- Replaces the plain mid-bit receiver where robustness matters: 2-FF input synchroniser, majority-vote bit sampling, false-start rejection, framing-error reporting.
- Sits between the uart_rx pad and byte-level consumers (command parser, FIFO); drop-in alongside uart_tx in the UART top level.

Parameters:
- SYS_CLOCK, 50_000_000, system clock frequency in Hz.
- BAUDRATE, 115200, line bit rate in baud.
- OS_DIV, SYS_CLOCK/(BAUDRATE*16), clocks per oversample tick (integer division; 27 at defaults).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last correctly received byte.
- rx_vld  output  1  one-clock pulse; rx_data is valid in the same cycle.
- frame_err  output  1  one-clock pulse; stop bit sampled low.
- parity_err  output  1  one-clock pulse; parity mismatch (see Optional Feature).
- rx_busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset: async assert, sync release; all outputs 0, rx_data=8'h00. Synchroniser FFs reset to 1. State goes to IDLE; tick and sample counters go to 0.
- Synchroniser: 2 FFs on uart_rx; all logic uses the synchronised copy (2-clock input latency).
- Tick generator:
  - Counter 0..OS_DIV-1; tick pulses when count = OS_DIV-1.
  - Held at 0 in IDLE; restarts at the start-edge detection so phase aligns to the frame.
- Sample counter: 4-bit, 0..15 per bit, advances on tick. Bit value = majority of the samples taken at counts 7, 8 and 9; the decision is made at count 9.
- FSM:
  - IDLE: on a synchronised 1->0 transition -> START; rx_busy=1.
  - START: at count 9, majority=1 -> IDLE (false start, no pulses); majority=0 -> continue to count 15 -> DATA.
  - DATA: 8 bits, shifted in LSB first; after bit 7 completes -> PARITY if the macro is defined, otherwise -> STOP.
  - STOP: decision at count 9, then go to IDLE immediately (do not wait for the end of the stop bit, so back-to-back frames are tolerated).
    - Stop majority=1: rx_data<=shift register and rx_vld=1 for 1 clock.
    - Stop majority=0: frame_err=1 for 1 clock; rx_data and rx_vld unchanged/0.
- Latency: rx_vld is asserted 1 clock after the stop-bit count-9 tick, ≈9.6 bit times after the line start edge plus 2 sync clocks.
- rx_data holds its value until the next good frame; no overwrite on any error.
- Line low in IDLE with no falling edge (break or stuck-low): no new frame starts until the line returns high and falls again.
- rst_n asserted mid-frame: immediate abort to IDLE; the partial byte is discarded.
- rx_vld, frame_err and parity_err are never asserted in the same cycle except frame_err+parity_err together (macro defined).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; PARITY state after DATA, sampled the same way.
  - Even parity checked over the 8 data bits plus the parity bit.
  - Mismatch: parity_err pulses in the stop-decision cycle and rx_vld is suppressed.
- Undefined: 8N1; no PARITY state; parity_err tied 0.

Test Plan:
- 0x55 sent at 434 clk/bit (50 MHz) -> exactly one rx_vld pulse, rx_data=8'h55, frame_err=0, rx_busy low afterwards.
- 100-clock low glitch on an idle line -> no rx_vld, no frame_err, FSM back in IDLE by glitch end+~10 ticks.
- 0xA3 with stop bit driven 0 after a prior good 0x11 -> frame_err single pulse, no rx_vld, rx_data stays 8'h11.
- 0x00 then 0xFF back-to-back, zero idle gap, transmitter at +2% baud -> two rx_vld pulses, data 8'h00 then 8'hFF.
- rst_n pulsed low during bit 4 of 0xC3 -> all outputs 0 immediately; next frame 0x3C -> rx_data=8'h3C, single rx_vld.
- UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> parity_err pulse, no rx_vld; parity bit 1 -> rx_vld, rx_data=8'h07.
